// File: rtl/mac_seq_ctrl_if.sv
// Command/status bundle between the host side and the MAC sequencer.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while ready=1; op_valid (MAC_SEQ_CTRL_STALL_EN) stalls issue.
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              abort;
`ifdef MAC_SEQ_CTRL_STALL_EN
  logic              op_valid;
`endif
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic              op_le;
  logic              acc_clr;
  logic              acc_en;
  logic              done;

  // Host / command side
  modport master (
`ifdef MAC_SEQ_CTRL_STALL_EN
    output op_valid,
`endif
    output start, len, abort,
    input  ready, busy, addr, op_le, acc_clr, acc_en, done
  );

  // Sequencer side
  modport slave (
`ifdef MAC_SEQ_CTRL_STALL_EN
    input  op_valid,
`endif
    input  start, len, abort,
    output ready, busy, addr, op_le, acc_clr, acc_en, done
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: clear accumulator, walk operand addresses, fire acc_en PIPE_LAT after op_le, pulse done.
// Latency: done at cycle len+2+PIPE_LAT after start acceptance (cycle 2 for len=0).
// Backpressure: start ignored while busy; optional MAC_SEQ_CTRL_STALL_EN adds op_valid to hold issue.
module mac_seq_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 2   // legal 1..8
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_seq_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic [LEN_W-1:0]    remaining;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          drain_cnt;
  logic [PIPE_LAT-1:0] acc_line;
  logic                issue_adv;
  logic                kill;

  // An issue slot is consumed only when the operand is actually latched.
`ifdef MAC_SEQ_CTRL_STALL_EN
  assign issue_adv = (state == S_ISSUE) && bus.op_valid;
`else
  assign issue_adv = (state == S_ISSUE);
`endif

  // Abort has effect only on an active run; in IDLE it just masks start.
  assign kill = bus.abort && (state != S_IDLE);

  assign bus.ready   = (state == S_IDLE);
  assign bus.busy    = (state != S_IDLE);
  assign bus.addr    = addr_q;
  assign bus.op_le   = issue_adv;
  assign bus.acc_clr = (state == S_CLR);
  assign bus.done    = (state == S_DONE);
  assign bus.acc_en  = acc_line[PIPE_LAT-1];

  // Main sequencer: state, remaining count, operand address and drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      addr_q    <= '0;
      drain_cnt <= '0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state     <= S_CLR;
            remaining <= bus.len;
            addr_q    <= '0;
          end
        end
        S_CLR: begin
          state <= (remaining == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (issue_adv) begin
            addr_q    <= addr_q + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              state     <= S_DRAIN;
              drain_cnt <= 4'(PIPE_LAT - 1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // acc_en delay line: mirrors op_le PIPE_LAT cycles later; flushed on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_line <= '0;
    end else if (kill) begin
      acc_line <= '0;
    end else begin
      acc_line[0] <= issue_adv;
      for (int i = 1; i < PIPE_LAT; i++) begin
        acc_line[i] <= acc_line[i-1];
      end
    end
  end

endmodule
